boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 33 +++
 rtl/boot_watchdog.sv | 32 +++
 rtl/boot_sequencer.sv | 132 +++++++++++++
 tb/tb_boot_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared encodings for the boot sequencer: FSM states, fault causes and datapath widths.
package boot_pkg;

   localparam int unsigned STATE_W  = 3;
   localparam int unsigned FAULT_W  = 4;
   localparam int unsigned SETTLE_W = 8;
   localparam int unsigned WDOG_W   = 24;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_CALIB = 3'd0,
      ST_SETTLE     = 3'd1,
      ST_CLEAR_GO   = 3'd2,
      ST_CLEAR_WAIT = 3'd3,
      ST_SD_GO      = 3'd4,
      ST_SD_WAIT    = 3'd5,
      ST_RUN        = 3'd6,
      ST_FAULT      = 3'd7
   } boot_state_e;

   localparam logic [FAULT_W-1:0] FC_NONE       = 4'd0;
   localparam logic [FAULT_W-1:0] FC_MEM        = 4'd1;
   localparam logic [FAULT_W-1:0] FC_SD         = 4'd2;
   localparam logic [FAULT_W-1:0] FC_CALIB_LOST = 4'd3;
   localparam logic [FAULT_W-1:0] FC_TO_CLEAR   = 4'd4;
   localparam logic [FAULT_W-1:0] FC_TO_SD      = 4'd5;

   // States in which losing memory calibration is fatal
   function automatic logic calib_guarded(boot_state_e s);
      return (s == ST_CLEAR_GO) || (s == ST_CLEAR_WAIT) || (s == ST_SD_GO) ||
             (s == ST_SD_WAIT)  || (s == ST_RUN);
   endfunction

endpackage

// File: rtl/boot_watchdog.sv
// Per-phase watchdog: cleared by load, counts while enabled, flags expiry at LIMIT cycles.
// Only compiled when BOOT_TIMEOUT_EN is defined.
`ifdef BOOT_TIMEOUT_EN
module boot_watchdog
   import boot_pkg::*;
#(
   parameter logic [WDOG_W-1:0] LIMIT = 24'd10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expired_c
);

   logic [WDOG_W-1:0] count;

   // Hold at the limit so a lingering enable cannot wrap back to zero
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (enable && !expired_c) begin
         count <= count + WDOG_W'(1);
      end
   end

   assign expired_c = enable && (count == (LIMIT - WDOG_W'(1)));

endmodule
`endif

// File: rtl/boot_sequencer.sv
// Power-on sequencer: memory calibration settle, screen clear, SD image load, then CPU release.
// Define BOOT_TIMEOUT_EN to add a per-phase watchdog on the clear and SD wait states.
module boot_sequencer
   import boot_pkg::*;
#(
   parameter int unsigned       CALIB_SETTLE   = 16,
   parameter logic [WDOG_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_calib_done,
   input  logic               mem_error,
   input  logic               clear_screen_done,
   input  logic               sdcard_read_done,
   input  logic               sdcard_error,
   output logic               clear_screen_start,
   output logic               sdcard_read_start,
   output logic               cpu_rst,
   output logic [STATE_W-1:0] boot_state,
   output logic [FAULT_W-1:0] fault_code
);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(CALIB_SETTLE - 1);

   if ((CALIB_SETTLE < 1) || (CALIB_SETTLE > 255) || (TIMEOUT_CYCLES == '0)) begin : g_bad_cfg
      $error("boot_sequencer: CALIB_SETTLE must be 1..255 and TIMEOUT_CYCLES nonzero");
   end

   boot_state_e         state;
   boot_state_e         state_next;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [SETTLE_W-1:0] settle_next;
   logic [FAULT_W-1:0]  fault_next;

`ifdef BOOT_TIMEOUT_EN
   logic wd_load;
   logic wd_enable;
   logic wd_expired_c;

   assign wd_load   = (state == ST_CLEAR_GO) || (state == ST_SD_GO);
   assign wd_enable = (state == ST_CLEAR_WAIT) || (state == ST_SD_WAIT);

   boot_watchdog #(
      .LIMIT(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .load     (wd_load),
      .enable   (wd_enable),
      .expired_c(wd_expired_c)
   );
`endif

   // Next-state logic; fault overrides are applied last so they win over the phase transitions
   always_comb begin
      state_next  = state;
      settle_next = settle_cnt;
      fault_next  = fault_code;

      case (state)
         ST_WAIT_CALIB: begin
            settle_next = '0;
            if (mem_calib_done) state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!mem_calib_done)               state_next  = ST_WAIT_CALIB;
            else if (settle_cnt == SETTLE_LAST) state_next  = ST_CLEAR_GO;
            else                                settle_next = settle_cnt + SETTLE_W'(1);
         end
         ST_CLEAR_GO: state_next = ST_CLEAR_WAIT;
         ST_CLEAR_WAIT: begin
            if (clear_screen_done) begin
               state_next = ST_SD_GO;
            end
`ifdef BOOT_TIMEOUT_EN
            else if (wd_expired_c) begin
               state_next = ST_FAULT;
               fault_next = FC_TO_CLEAR;
            end
`endif
         end
         ST_SD_GO: state_next = ST_SD_WAIT;
         ST_SD_WAIT: begin
            if (sdcard_error) begin
               state_next = ST_FAULT;
               fault_next = FC_SD;
            end else if (sdcard_read_done) begin
               state_next = ST_RUN;
            end
`ifdef BOOT_TIMEOUT_EN
            else if (wd_expired_c) begin
               state_next = ST_FAULT;
               fault_next = FC_TO_SD;
            end
`endif
         end
         default: ;
      endcase

      if (state != ST_FAULT) begin
         if (mem_error) begin
            state_next = ST_FAULT;
            fault_next = FC_MEM;
         end else if (calib_guarded(state) && !mem_calib_done) begin
            state_next = ST_FAULT;
            fault_next = FC_CALIB_LOST;
         end
      end
   end

   // State and registered outputs; pulses are aligned with the GO states they accompany
   always_ff @(posedge clk) begin
      if (rst) begin
         state              <= ST_WAIT_CALIB;
         settle_cnt         <= '0;
         fault_code         <= FC_NONE;
         clear_screen_start <= 1'b0;
         sdcard_read_start  <= 1'b0;
         cpu_rst            <= 1'b1;
      end else begin
         state              <= state_next;
         settle_cnt         <= settle_next;
         fault_code         <= fault_next;
         clear_screen_start <= (state_next == ST_CLEAR_GO);
         sdcard_read_start  <= (state_next == ST_SD_GO);
         cpu_rst            <= (state != ST_RUN);
      end
   end

   assign boot_state = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: each scenario is a set of event times from which the
// expected output timeline is derived arithmetically. Define BOOT_TIMEOUT_EN to check the watchdog.
module tb_boot_sequencer;

   localparam int S   = 16;
   localparam int TO  = 100;
   localparam int INF = 1_000_000_000;

   localparam int ST_WAIT   = 0;
   localparam int ST_SETTLE = 1;
   localparam int ST_CGO    = 2;
   localparam int ST_CWAIT  = 3;
   localparam int ST_SGO    = 4;
   localparam int ST_SWAIT  = 5;
   localparam int ST_RUN    = 6;
   localparam int ST_FAULT  = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       calib = 1'b0;
   logic       mem_err = 1'b0;
   logic       clr_done = 1'b0;
   logic       sd_done = 1'b0;
   logic       sd_err = 1'b0;
   logic       clr_start;
   logic       sd_start;
   logic       cpu_rst;
   logic [2:0] bstate;
   logic [3:0] fcode;

   int checks = 0;
   int errors = 0;

   // Scenario: calib rises at c0 (optionally drops at g and returns at c), clear done from p1+dc,
   // SD done from p2+ds; ft selects 0 none, 1 mem_error, 2 calib loss, 3 sd_error, 4 clear never done.
   int c0, g, c, glitch, dc, ds, ft, fcyc;
   int p1, p2, r, f, fc, len;

   boot_sequencer #(
      .CALIB_SETTLE  (S),
      .TIMEOUT_CYCLES(24'(TO))
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .mem_calib_done    (calib),
      .mem_error         (mem_err),
      .clear_screen_done (clr_done),
      .sdcard_read_done  (sd_done),
      .sdcard_error      (sd_err),
      .clear_screen_start(clr_start),
      .sdcard_read_start (sd_start),
      .cpu_rst           (cpu_rst),
      .boot_state        (bstate),
      .fault_code        (fcode)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %0d expected %0d", tag, n, obs, exp);
      end
   endtask

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Event times of the fault-free sequence
   task automatic plan();
      p1 = c + S + 1;
      p2 = imax(p1 + dc, p1 + 1) + 1;
      r  = imax(p2 + ds, p2 + 1) + 1;
   endtask

   task automatic finalize();
      f  = INF;
      fc = 0;
      case (ft)
         1: begin f = fcyc + 1; fc = 1; end
         2: begin f = fcyc + 1; fc = 3; end
         3: begin f = r;        fc = 2; end
         4: begin
`ifdef BOOT_TIMEOUT_EN
            f = p1 + 1 + TO; fc = 4;
`endif
         end
         default: ;
      endcase
      if (ft == 4) len = (f == INF) ? p1 + 1002 : f + 4;
      else         len = ((f == INF) ? r : imax(r, f)) + 4;
   endtask

   function automatic int nominal(input int n);
      if (n <= c)  return (glitch != 0 && n > c0 && n <= g) ? ST_SETTLE : ST_WAIT;
      if (n < p1)  return ST_SETTLE;
      if (n == p1) return ST_CGO;
      if (n < p2)  return ST_CWAIT;
      if (n == p2) return ST_SGO;
      if (n < r)   return ST_SWAIT;
      return ST_RUN;
   endfunction

   function automatic int expected(input int n);
      return (n >= f) ? ST_FAULT : nominal(n);
   endfunction

   function automatic logic calib_at(input int n);
      logic base;
      base = (glitch != 0) ? ((n >= c0 && n < g) || n >= c) : (n >= c);
      return base && !(ft == 2 && n >= fcyc);
   endfunction

   task automatic check_reset(input string name);
      check({name, ".rst_state"},  0, 8'(bstate),    8'(ST_WAIT));
      check({name, ".rst_clear"},  0, 8'(clr_start), 8'd0);
      check({name, ".rst_sd"},     0, 8'(sd_start),  8'd0);
      check({name, ".rst_cpu"},    0, 8'(cpu_rst),   8'd1);
      check({name, ".rst_fault"},  0, 8'(fcode),     8'd0);
   endtask

   // Drive one scenario cycle by cycle, then pulse rst from wherever it ended (RUN or FAULT)
   task automatic run_scen(input string name);
      int e;
      int pe;
      finalize();
      for (int n = 0; n < len; n++) begin
         calib    = calib_at(n);
         mem_err  = (ft == 1) && (n >= fcyc);
         clr_done = (n >= p1 + dc);
         sd_done  = (n >= p2 + ds);
         sd_err   = (ft == 3) && (n >= p2 + ds);
         e  = expected(n);
         pe = (n == 0) ? ST_WAIT : expected(n - 1);
         check({name, ".state"}, n, 8'(bstate),    8'(e));
         check({name, ".clear"}, n, 8'(clr_start), 8'(e == ST_CGO));
         check({name, ".sd"},    n, 8'(sd_start),  8'(e == ST_SGO));
         check({name, ".cpu"},   n, 8'(cpu_rst),   8'(pe != ST_RUN));
         check({name, ".fault"}, n, 8'(fcode),     8'((n >= f) ? fc : 0));
         step();
      end
      rst = 1'b1;
      step();
      check_reset(name);
      rst = 1'b0;
   endtask

   initial begin
      step();
      step();
      check_reset("init");
      rst = 1'b0;

      // Nominal boot: pulse at 5+16+1, clear done 3 after, SD done 10 after, reset while in RUN
      c0 = 5; c = 5; glitch = 0; dc = 3; ds = 10; ft = 0; fcyc = 0;
      plan();
      run_scen("boot");

      // Calib dropped on the 8th SETTLE cycle, then a fresh full settle
      c0 = 2; g = 10; c = 12; glitch = 1; dc = 0; ds = 0; ft = 0; fcyc = 0;
      plan();
      run_scen("settle_drop");

      // mem_error and sdcard_read_done in the same SD_WAIT cycle
      c0 = 3; c = 3; glitch = 0; dc = 1; ds = 4; ft = 1;
      plan();
      fcyc = r - 1;
      run_scen("mem_vs_sd");

      // Calibration lost while running
      c0 = 1; c = 1; glitch = 0; dc = 2; ds = 2; ft = 2;
      plan();
      fcyc = r + 1;
      run_scen("calib_lost_run");

      // SD error and done together on the first SD_WAIT cycle
      c0 = 0; c = 0; glitch = 0; dc = 0; ds = 0; ft = 3; fcyc = 0;
      plan();
      run_scen("sd_error");

      // Clear never completes
      c0 = 4; c = 4; glitch = 0; dc = INF; ds = 0; ft = 4; fcyc = 0;
      plan();
      run_scen("clear_stall");

      for (int i = 0; i < 24; i++) begin
         c0     = int'($urandom_range(0, 6));
         glitch = int'($urandom_range(0, 1));
         if (glitch != 0) begin
            g = c0 + int'($urandom_range(1, S));
            c = g + int'($urandom_range(1, 4));
         end else begin
            g = c0;
            c = c0;
         end
         dc = int'($urandom_range(0, 5));
         ds = int'($urandom_range(0, 6));
         ft = int'($urandom_range(0, 3));
         plan();
         if (ft == 1)      fcyc = int'($urandom_range(0, r + 2));
         else if (ft == 2) fcyc = int'($urandom_range(p1, r + 2));
         else              fcyc = 0;
         run_scen("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
